// File: rtl/fifo_sc_prog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_sc_prog: single-clock FIFO, programmable thresholds, sticky errors.  |
// | Optional peak-occupancy output via macro FIFO_STATS_EN. Rev 1.0           |
// +--------------------------------------------------------------------------+
module fifo_sc_prog #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter bit SHOWAHEAD = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  input  logic [AWIDTH:0]   almost_full_thr_i,
  input  logic [AWIDTH:0]   almost_empty_thr_i,
  input  logic              err_clr_i,
  output logic [DWIDTH-1:0] q_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              ovf_o,
  output logic              unf_o
`ifdef FIFO_STATS_EN
  ,
  output logic [AWIDTH:0]   max_usedw_o
`endif
);

  localparam int                DEPTH     = 2**AWIDTH;
  localparam logic [AWIDTH:0]   c_DEPTH   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   c_CNT_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] c_PTR_ONE = AWIDTH'(1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic              empty_q, full_q, afull_q, aempty_q, ovf_q, unf_q;
  logic              wr_en, rd_en;

  always_comb begin
    wr_en   = wrreq_i & ~full_q;
    rd_en   = rdreq_i & ~empty_q;
    usedw_d = usedw_q;
    if (wr_en && !rd_en) begin
      usedw_d = usedw_q + c_CNT_ONE;
    end else if (!wr_en && rd_en) begin
      usedw_d = usedw_q - c_CNT_ONE;
    end
  end

  // Status flags are computed from the next-state count so they move with usedw_o.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= (almost_full_thr_i == '0);
      aempty_q <= (almost_empty_thr_i != '0);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      usedw_q  <= usedw_d;
      empty_q  <= (usedw_d == '0);
      full_q   <= (usedw_d == c_DEPTH);
      afull_q  <= (usedw_d >= almost_full_thr_i);
      aempty_q <= (usedw_d < almost_empty_thr_i);
      if (wrreq_i && full_q) begin
        ovf_q <= 1'b1;
      end else if (err_clr_i) begin
        ovf_q <= 1'b0;
      end
      if (rdreq_i && empty_q) begin
        unf_q <= 1'b1;
      end else if (err_clr_i) begin
        unf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !srst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  generate
    if (SHOWAHEAD) begin : g_showahead
      assign q_o = mem_q[rd_ptr_q];
    end else begin : g_registered
      logic [DWIDTH-1:0] q_q;
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          q_q <= '0;
        end else if (rd_en) begin
          q_q <= mem_q[rd_ptr_q];
        end
      end
      assign q_o = q_q;
    end
  endgenerate

`ifdef FIFO_STATS_EN
  logic [AWIDTH:0] max_usedw_q;
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      max_usedw_q <= '0;
    end else if (err_clr_i) begin
      max_usedw_q <= usedw_q;
    end else if (usedw_q > max_usedw_q) begin
      max_usedw_q <= usedw_q;
    end
  end
  assign max_usedw_o = max_usedw_q;
`endif

  assign usedw_o        = usedw_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign ovf_o          = ovf_q;
  assign unf_o          = unf_q;

endmodule
`default_nettype wire
